spi_sclk_gen: RTL
=================

# spi_sclk_gen

Parametrised SPI serial-clock generator. It produces a finite burst of a programmable number of SCLK periods at a programmable even divisor of i_clk, with selectable polarity (CPOL) and phase (CPHA). It emits one-cycle sample and shift strobes aligned to SCLK edges. It sits between the SPI controller FSM and the shift register, and replaces the fixed 8-bit, mode-0-only divider.

## Interface
- DIV_W, 8: width of the divisor field; divisors up to 2^DIV_W-2.
- CNT_W, 5: width of the bit-count field; bursts up to 2^CNT_W bits.
- DEF_DIV, 2: divisor loaded at reset.
- DEF_NBITS, 8: burst length loaded at reset.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_cfg_we  in  1  config write strobe; honoured only in IDLE.
- i_cfg_div  in  DIV_W  requested divisor.
- i_cfg_nbits  in  CNT_W  burst length in bits; 0 means 2^CNT_W.
- i_cfg_cpol  in  1  SCLK idle level.
- i_cfg_cpha  in  1  0: sample on the lead edge, shift on the trail edge; 1: the reverse.
- i_start_n  in  1  start request, active-low, level-sampled in IDLE.
- o_ready  out  1  high in IDLE; configuration and start are accepted.
- o_sclk  out  1  serial clock.
- o_lead_edge / o_trail_edge  out  1  high in the first cycle o_sclk shows its new level after a leading or trailing transition.
- o_sample / o_shift  out  1  CPHA-mapped copies of the lead and trail strobes.
- o_bit_count  out  CNT_W+1  bits completed in the current or last burst.
- o_done  out  1  one-cycle pulse at the end of a burst.

## Operation
- State machine: IDLE -> RUN -> DONE -> IDLE.
- Effective divisor D = max(2, i_cfg_div with bit 0 cleared), so odd values round down and 0 or 1 become 2. Half period H = D/2 cycles.
- IDLE:
  - i_cfg_we=1 latches div, nbits, cpol and cpha. Config writes take priority over a simultaneous start; that start is dropped.
  - Otherwise i_start_n=0 clears the fast counter and o_bit_count and enters RUN.
- RUN:
  - The fast counter counts 0..H-1. On H-1 it wraps and o_sclk toggles.
  - Toggles alternate lead, trail, starting with lead. Each trail increments o_bit_count.
  - After trail number N (N = nbits, or 2^CNT_W when nbits is 0), the next state is DONE.
- DONE: lasts one cycle with o_done=1, then returns to IDLE.
- o_sclk equals the latched CPOL in IDLE and DONE. A CPOL write is visible on o_sclk the cycle after the write.
- i_start_n and i_cfg_we are ignored outside IDLE.
- Strobe mapping:
  - CPHA=0: o_sample = o_lead_edge, o_shift = o_trail_edge.
  - CPHA=1: o_shift = o_lead_edge, o_sample = o_trail_edge.
- Reset values: o_ready=0 while reset is asserted, 1 in the first cycle after release. o_sclk=0, all strobes 0, o_bit_count=0, o_done=0. Config returns to DEF_DIV, DEF_NBITS, cpol=0, cpha=0.
- Reset mid-burst: all outputs take their reset values at the next edge. No further strobes or o_done follow.

## Timing
- Cycle 0 is the first cycle in RUN, i.e. the edge where start was sampled.
- Toggles are visible in cycles kH for k = 1..2N.
  - Leads occur at odd k, trails at even k.
  - The lead and trail strobes are high exactly in those cycles.
- o_bit_count reads m from cycle 2mH onward.
- o_done is high in cycle 2NH+1; o_ready=1 from cycle 2NH+2.
- Minimum start-to-start spacing is 2NH+2 cycles.
- No strobe fires in IDLE or DONE.

## Configuration
- SPI_SCLK_ABORT_EN defined:
  - Adds input i_abort (1 bit).
  - i_abort=1 in RUN sends the FSM to DONE at the next edge. o_sclk returns to CPOL on that same edge.
  - No strobes fire in the abort cycle.
  - o_bit_count holds the number of trails completed.
  - o_done pulses as normal.
  - i_abort is ignored in IDLE and DONE.
- Not defined: the port is absent and bursts always run to completion.

## Test plan
- Reset release, start with defaults (D=2, N=8): o_sclk toggles in cycles 1..16, lead strobes in odd cycles, o_bit_count=8 in cycle 16, o_done in cycle 17, o_ready in cycle 18.
- cfg div=6, nbits=3, cpol=1, cpha=1, then start: o_sclk idles 1, toggles in cycles 3,6,…,18, o_shift at 3/9/15, o_sample at 6/12/18, o_done in cycle 19.
- cfg div=5, then div=0: the period measures 4 cycles, then 2 cycles. nbits=0 with CNT_W=5 gives 32 bits and o_bit_count=32.
- i_cfg_we with i_start_n=0 in the same cycle: config is latched, no burst starts. A start and a cfg write during RUN are both ignored; the latched config is unchanged.
- Reset asserted in cycle 5 of a default burst: o_sclk=0 and o_bit_count=0 next cycle, no o_done, o_ready=1 after release.
- With SPI_SCLK_ABORT_EN and D=4, i_abort in cycle 7: o_sclk=CPOL in cycle 8, o_bit_count=1, o_done in cycle 8.

Source files
------------

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: a burst of N SCLK periods at an even divisor of i_clk, with CPOL/CPHA strobes.
// Optional feature macro: SPI_SCLK_ABORT_EN (adds i_abort to end a burst early).
module spi_sclk_gen #(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 5,
  parameter int DEF_DIV   = 2,
  parameter int DEF_NBITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_nbits,
  input  logic             i_cfg_cpol,
  input  logic             i_cfg_cpha,
  input  logic             i_start_n,
`ifdef SPI_SCLK_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_ready,
  output logic             o_sclk,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic             o_sample,
  output logic             o_shift,
  output logic [CNT_W:0]   o_bit_count,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] ONE_DIV = DIV_W'(1);
  localparam logic [CNT_W:0]   ONE_CNT = (CNT_W + 1)'(1);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] nbits_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [DIV_W-1:0] cnt_q;
  logic             sclk_q;
  logic             lead_q;
  logic             trail_q;
  logic             sample_q;
  logic             shift_q;
  logic [CNT_W:0]   bit_count_q;
  logic             done_q;
  logic             ready_q;

  logic [DIV_W-1:0] half_s;
  logic [DIV_W-1:0] last_cnt_s;
  logic [CNT_W:0]   nbits_full_s;
  logic             abort_s;
  logic             is_lead_s;

  // Derived burst parameters: H = max(1, div/2), N = nbits with 0 meaning 2^CNT_W.
  always_comb begin
    if ((div_q >> 1) == '0) begin
      half_s = ONE_DIV;
    end else begin
      half_s = div_q >> 1;
    end
    last_cnt_s = half_s - ONE_DIV;
    if (nbits_q == '0) begin
      nbits_full_s = {1'b1, {CNT_W{1'b0}}};
    end else begin
      nbits_full_s = {1'b0, nbits_q};
    end
`ifdef SPI_SCLK_ABORT_EN
    abort_s = i_abort;
`else
    abort_s = 1'b0;
`endif
    // A toggle away from the idle level is a lead edge, back towards it a trail edge.
    is_lead_s = (sclk_q == cpol_q);
  end

  // Burst FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= DIV_W'(DEF_DIV);
      nbits_q     <= CNT_W'(DEF_NBITS);
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= '0;
      sclk_q      <= 1'b0;
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
      sample_q    <= 1'b0;
      shift_q     <= 1'b0;
      bit_count_q <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (i_cfg_we) begin
            div_q   <= i_cfg_div;
            nbits_q <= i_cfg_nbits;
            cpol_q  <= i_cfg_cpol;
            cpha_q  <= i_cfg_cpha;
            sclk_q  <= i_cfg_cpol;
          end else if (!i_start_n) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            bit_count_q <= '0;
            ready_q     <= 1'b0;
          end else begin
            sclk_q <= cpol_q;
          end
        end
        S_RUN: begin
          if (abort_s || (bit_count_q == nbits_full_s)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            sclk_q  <= cpol_q;
          end else if (cnt_q == last_cnt_s) begin
            cnt_q    <= '0;
            sclk_q   <= ~sclk_q;
            lead_q   <= is_lead_s;
            trail_q  <= ~is_lead_s;
            sample_q <= cpha_q ? ~is_lead_s : is_lead_s;
            shift_q  <= cpha_q ? is_lead_s : ~is_lead_s;
            if (!is_lead_s) begin
              bit_count_q <= bit_count_q + ONE_CNT;
            end else begin
              bit_count_q <= bit_count_q;
            end
          end else begin
            cnt_q <= cnt_q + ONE_DIV;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          sclk_q  <= cpol_q;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_sclk       = sclk_q;
  assign o_lead_edge  = lead_q;
  assign o_trail_edge = trail_q;
  assign o_sample     = sample_q;
  assign o_shift      = shift_q;
  assign o_bit_count  = bit_count_q;
  assign o_done       = done_q;

endmodule
